// File: rtl/cdec_memsys.sv
// Small memory system: RAM, synchronised input ports, output port registers,
// a new-data status register and a request/acknowledge programmer port.
module cdec_memsys #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int N_IN    = 1,
  parameter int N_OUT   = 2,
  parameter int IO_BASE = 2**AW-8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       MA,
  input  logic [DW-1:0]       WD,
  output logic [DW-1:0]       RD,
  input  logic [N_IN*DW-1:0]  iport,
  output logic [N_OUT*DW-1:0] oport,
  input  logic                prg_req,
  input  logic                prg_we,
  input  logic [AW-1:0]       prg_MA,
  input  logic [DW-1:0]       prg_WD,
  output logic [DW-1:0]       prg_RD,
  output logic                prg_ack
);

  localparam int STAT_ADDR = IO_BASE + N_IN + N_OUT;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

  state_t          state, next_state;
  logic [DW-1:0]   mem [IO_BASE];
  logic [DW-1:0]   s1 [N_IN];
  logic [DW-1:0]   s2 [N_IN];
  logic [DW-1:0]   s3 [N_IN];
  logic [N_IN-1:0] flag;
  logic            lat_we;
  logic [AW-1:0]   lat_ma;
  logic [DW-1:0]   lat_wd;
  logic            prg_fire;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  // Whole address map as seen by either master; unused I/O reads as zero.
  function automatic logic [DW-1:0] read_map(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    if (int'(a) < IO_BASE) r = mem[a];
    for (int k = 0; k < N_IN; k++)
      if (a == AW'(IO_BASE + k)) r = s2[k];
    for (int j = 0; j < N_OUT; j++)
      if (a == AW'(IO_BASE + N_IN + j)) r = oport[j*DW +: DW];
    if (a == AW'(STAT_ADDR)) r = DW'(flag);
    return r;
  endfunction

  assign RD      = read_map(MA);
  assign prg_ack = (state == DONE);

  always_comb begin
    next_state = state;
    prg_fire   = 1'b0;
    case (state)
      IDLE:    if (prg_req) next_state = ACCESS;
      ACCESS: begin
        // The core owns the bus whenever it writes; a reset edge aborts.
        if (!we && !reset) begin
          prg_fire   = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = prg_req ? RELEASE : IDLE;
      RELEASE: if (!prg_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single write port shared by core and programmer; they never overlap.
  assign wr_en   = we | (prg_fire & lat_we);
  assign wr_addr = we ? MA : lat_ma;
  assign wr_data = we ? WD : lat_wd;

  always_ff @(posedge clock) begin
    if (wr_en && int'(wr_addr) < IO_BASE) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      lat_we <= 1'b0;
      lat_ma <= '0;
      lat_wd <= '0;
      prg_RD <= '0;
      oport  <= '0;
      flag   <= '0;
      for (int k = 0; k < N_IN; k++) begin
        s1[k] <= '0;
        s2[k] <= '0;
        s3[k] <= '0;
      end
    end else begin
      state <= next_state;
      if (state == IDLE && prg_req) begin
        lat_we <= prg_we;
        lat_ma <= prg_MA;
        lat_wd <= prg_WD;
      end
      if (prg_fire) prg_RD <= lat_we ? '0 : read_map(lat_ma);
      for (int j = 0; j < N_OUT; j++)
        if (wr_en && wr_addr == AW'(IO_BASE + N_IN + j))
          oport[j*DW +: DW] <= wr_data;
      for (int k = 0; k < N_IN; k++) begin
        s1[k] <= iport[k*DW +: DW];
        s2[k] <= s1[k];
        s3[k] <= s2[k];
        // A change seen this cycle outranks a simultaneous core read.
        if (s2[k] != s3[k])
          flag[k] <= 1'b1;
        else if (!we && MA == AW'(IO_BASE + k))
          flag[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdec_memsys.sv
// Directed bench for cdec_memsys with a transaction-level reference model
// compared every cycle, plus literal spot checks.
module tb_cdec_memsys;
  localparam int DW = 8, AW = 8, N_IN = 1, N_OUT = 2, IO_BASE = 248;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         we = 1'b0;
  logic [7:0]   MA = '0, WD = '0, RD;
  logic [7:0]   iport = '0;
  logic [15:0]  oport;
  logic         prg_req = 1'b0, prg_we = 1'b0;
  logic [7:0]   prg_MA = '0, prg_WD = '0, prg_RD;
  logic         prg_ack;

  int total = 0;
  int bad   = 0;

  cdec_memsys #(.DW(DW), .AW(AW), .N_IN(N_IN), .N_OUT(N_OUT), .IO_BASE(IO_BASE)) dut (
    .clock(clock), .reset(reset), .we(we), .MA(MA), .WD(WD), .RD(RD),
    .iport(iport), .oport(oport),
    .prg_req(prg_req), .prg_we(prg_we), .prg_MA(prg_MA), .prg_WD(prg_WD),
    .prg_RD(prg_RD), .prg_ack(prg_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Reference model: memory map contents, input history, programmer progress.
  logic [7:0] mram [256];
  bit         mknown [256];
  logic [7:0] m_op [2];
  logic [7:0] m_s1, m_s2, m_s3;
  bit         m_flag, n_flag;
  bit         p_busy, p_ack, p_wait;
  bit         l_we;
  logic [7:0] l_ma, l_wd, m_prd;
  bit         started = 1'b0;

  function automatic logic [7:0] mread(input logic [7:0] a);
    if (a < 8'd248) return mram[a];
    case (a)
      8'hF8:   return m_s2;
      8'hF9:   return m_op[0];
      8'hFA:   return m_op[1];
      8'hFB:   return {7'b0, m_flag};
      default: return 8'h00;
    endcase
  endfunction

  task automatic mwrite(input logic [7:0] a, input logic [7:0] d);
    if (a < 8'd248) begin
      mram[a]   = d;
      mknown[a] = 1'b1;
    end else if (a == 8'hF9) m_op[0] = d;
    else if (a == 8'hFA) m_op[1] = d;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_op[0] = '0; m_op[1] = '0;
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      m_flag = 0; p_busy = 0; p_ack = 0; p_wait = 0;
      l_we = 0; l_ma = '0; l_wd = '0; m_prd = '0;
      started = 1'b1;
    end else begin
      n_flag = m_flag;
      if (m_s2 != m_s3) n_flag = 1'b1;
      else if (!we && MA == 8'hF8) n_flag = 1'b0;
      if (p_ack) begin
        p_ack  = 1'b0;
        p_wait = prg_req;
      end else if (p_wait) begin
        if (!prg_req) p_wait = 1'b0;
      end else if (p_busy) begin
        if (!we) begin
          if (l_we) begin
            m_prd = '0;
            mwrite(l_ma, l_wd);
          end else m_prd = mread(l_ma);
          p_busy = 1'b0;
          p_ack  = 1'b1;
        end
      end else if (prg_req) begin
        l_we = prg_we; l_ma = prg_MA; l_wd = prg_WD;
        p_busy = 1'b1;
      end
      if (we) mwrite(MA, WD);
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = iport;
      m_flag = n_flag;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("ack", {31'b0, prg_ack}, {31'b0, p_ack});
      if (p_ack) check("prg_rd_model", {24'b0, prg_RD}, {24'b0, m_prd});
      check("oport_model", {16'b0, oport}, {16'b0, m_op[1], m_op[0]});
      if (MA >= 8'd248 || mknown[MA]) check("rd_model", {24'b0, RD}, {24'b0, mread(MA)});
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int acks;
    for (int i = 0; i < 256; i++) mknown[i] = 1'b0;
    tick; tick;
    check("reset_oport", {16'b0, oport}, 32'h0);
    check("reset_ack", {31'b0, prg_ack}, 32'h0);
    check("reset_prg_rd", {24'b0, prg_RD}, 32'h0);
    reset = 1'b0;

    // Core RAM and output port writes.
    we = 1; MA = 8'h10; WD = 8'hA5; tick;
    we = 0; #1;
    check("ram_rw", {24'b0, RD}, 32'hA5);
    we = 1; MA = 8'hF9; WD = 8'h3C; tick;
    we = 0; #1;
    check("oport0_wr", {24'b0, oport[7:0]}, 32'h3C);

    // Unused, STAT and iport addresses ignore writes.
    we = 1; MA = 8'hFC; WD = 8'h55; tick;
    MA = 8'hFB; WD = 8'hFF; tick;
    MA = 8'hF8; tick;
    we = 0; MA = 8'hFC; #1;
    check("unused_rd0", {24'b0, RD}, 32'h0);

    // Input port synchroniser and new-data flag.
    iport = 8'h5A; reset = 1; tick;
    reset = 0; MA = 8'hFB; tick; tick; tick;
    check("stat_set", {24'b0, RD}, 32'h01);
    MA = 8'hF8; #1;
    check("iport_rd", {24'b0, RD}, 32'h5A);
    tick;
    MA = 8'hFB; #1;
    check("stat_clr", {24'b0, RD}, 32'h00);

    // Programmer write then read.
    prg_req = 1; prg_we = 1; prg_MA = 8'h20; prg_WD = 8'h77; tick;
    check("pw_ack_n1", {31'b0, prg_ack}, 32'h0);
    tick;
    check("pw_ack_n2", {31'b0, prg_ack}, 32'h1);
    prg_req = 0; tick;
    MA = 8'h20; #1;
    check("pw_core_rd", {24'b0, RD}, 32'h77);
    prg_req = 1; prg_we = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (prg_ack) got = 1;
    end
    check("pr_ack_seen", {31'b0, got}, 32'h1);
    check("pr_data", {24'b0, prg_RD}, 32'h77);
    prg_req = 0; tick;

    // Core write stalls the programmer.
    we = 1; MA = 8'h30; WD = 8'hC3;
    prg_req = 1; prg_we = 1; prg_MA = 8'h40; prg_WD = 8'h11;
    for (int i = 0; i < 5; i++) tick;
    check("stall_no_ack", {31'b0, prg_ack}, 32'h0);
    we = 0; tick;
    check("stall_ack", {31'b0, prg_ack}, 32'h1);
    prg_req = 0; tick;
    MA = 8'h30; #1;
    check("stall_core_data", {24'b0, RD}, 32'hC3);
    MA = 8'h40; #1;
    check("stall_prg_data", {24'b0, RD}, 32'h11);

    // Long-held request gives a single transaction.
    prg_req = 1; prg_we = 1; prg_MA = 8'h50; prg_WD = 8'h22; acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (prg_ack) acks++;
    end
    prg_req = 0; tick;
    check("hold_one_ack", acks, 32'd1);
    MA = 8'h50; #1;
    check("hold_data", {24'b0, RD}, 32'h22);

    // Reset while a programmer write is in ACCESS.
    we = 1; MA = 8'hF9; WD = 8'h3C; tick;
    MA = 8'h60; WD = 8'h99; tick;
    we = 0;
    prg_req = 1; prg_we = 1; prg_MA = 8'h60; prg_WD = 8'hEE; tick;
    reset = 1; prg_req = 0; tick;
    reset = 0;
    check("abort_ack", {31'b0, prg_ack}, 32'h0);
    check("abort_oport", {16'b0, oport}, 32'h0);
    tick;
    check("abort_ack2", {31'b0, prg_ack}, 32'h0);
    MA = 8'h60; #1;
    check("abort_ram", {24'b0, RD}, 32'h99);
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdec_memsys.md
CDEC_MEMSYS -- requirements
Module: cdec_memsys

Interface
REQ-001 SHALL have parameters, one per line:
- DW, 8, data width
- AW, 8, address width
- N_IN, 1, input port count (1..DW)
- N_OUT, 2, output port count (>=1)
- IO_BASE, 2**AW-8, first I/O address; IO_BASE+N_IN+N_OUT+1 <= 2**AW
REQ-002 SHALL have ports, one per line:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  core write enable
- MA  in  AW  core address
- WD  in  DW  core write data
- RD  out  DW  core read data
- iport  in  N_IN*DW  input ports, port k at bits [k*DW +: DW], asynchronous to clock
- oport  out  N_OUT*DW  output port registers, same packing
- prg_req  in  1  programmer request, held until prg_ack
- prg_we  in  1  programmer write (1) / read (0)
- prg_MA  in  AW  programmer address
- prg_WD  in  DW  programmer write data
- prg_RD  out  DW  programmer read data, valid while prg_ack=1
- prg_ack  out  1  one-cycle completion pulse

Function
REQ-003 SHALL map addresses 0..IO_BASE-1 to RAM (IO_BASE words x DW).
REQ-004 SHALL map IO_BASE+k to iport k (read-only), for k < N_IN.
REQ-005 SHALL map IO_BASE+N_IN+j to oport j (read/write), for j < N_OUT.
REQ-006 SHALL map IO_BASE+N_IN+N_OUT to STAT (read-only); bit k = new-data flag of iport k; upper bits 0.
REQ-007 SHALL read 0 from unused I/O addresses and ignore writes to them; writes to iport or STAT addresses SHALL also be ignored.
REQ-008 RD SHALL be combinational from MA (RAM, oport register, synchronised iport, STAT); core write SHALL take effect at the clock edge with we=1.
REQ-009 Each iport SHALL pass through a 2-flop synchroniser (s1,s2) plus a history flop s3; reads SHALL return s2.
REQ-010 Flag k SHALL set on any cycle where s2!=s3; SHALL clear at the edge where the core reads IO_BASE+k (we=0); simultaneous set and clear: set wins.
REQ-011 Reading STAT SHALL NOT clear flags; programmer reads SHALL NOT clear flags.
REQ-012 Programmer FSM states: IDLE, ACCESS, DONE, RELEASE.
REQ-013 IDLE: on prg_req=1, SHALL latch prg_we/prg_MA/prg_WD and go to ACCESS.
REQ-014 ACCESS: if core we=1, SHALL stay in ACCESS (core has priority); else SHALL perform the latched access through the full address map and go to DONE.
REQ-015 DONE: prg_ack=1 for exactly this cycle; prg_RD SHALL hold the read data (0 for writes); then go to RELEASE if prg_req=1, else IDLE.
REQ-016 RELEASE: SHALL wait for prg_req=0, then go to IDLE; no access is repeated while prg_req stays high.
REQ-017 Minimum programmer latency: prg_req rising at edge n gives prg_ack=1 in cycle n+2.
REQ-018 Programmer and core accesses SHALL never write in the same cycle.

Reset
REQ-019 On reset=1: oport=0, prg_ack=0, prg_RD=0, flags=0, s1/s2/s3=0, FSM=IDLE, latched programmer fields=0.
REQ-020 RAM contents SHALL NOT be reset.
REQ-021 Reset mid-transaction SHALL abort it with no write and no prg_ack.
REQ-022 A nonzero iport at reset release SHALL set its flag within 3 cycles.

Verification
REQ-023 Core write MA=0x10 WD=0xA5, then read MA=0x10 -> RD=0xA5; MA=0xF9 WD=0x3C (oport0, defaults) -> oport[7:0]=0x3C after the edge.
REQ-024 iport=0x5A after reset -> read of 0xF8 gives 0x5A and STAT(0xFB)=0x01 by cycle 3; core read of 0xF8 -> STAT=0x00 next cycle.
REQ-025 Programmer write prg_MA=0x20 prg_WD=0x77 with we=0 -> prg_ack at cycle n+2; core read of 0x20 -> 0x77; programmer read of 0x20 -> prg_RD=0x77 with ack.
REQ-026 Hold we=1 for 5 cycles during ACCESS -> prg_ack delayed to the first cycle after we=0 plus 1; core write data intact.
REQ-027 Hold prg_req=1 for 10 cycles -> exactly one prg_ack pulse and one access.
REQ-028 Assert reset in ACCESS with prg_we=1 -> no RAM change, prg_ack stays 0, oport=0.
